// File: rtl/shift_add_controller_pkg.sv
// Shared definitions for the shift-add multiplier controller.
// Contents:
//   state_t : controller FSM states (IDLE -> RUN -> DONE -> IDLE)
//   cnt_w   : bit-count counter width for an N-bit operand
//   prod_w  : product width for an N-bit operand (2N)
package shift_add_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter only has to reach N-1; keep at least one bit for N == 1.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int prod_w(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/shift_add_controller_if.sv
// Request/response bus of the shift-add multiplier controller.
// Signals:
//   start        : request a multiply (honoured only while idle)
//   multiplicand : operand A
//   multiplier   : operand B
//   busy         : multiply in progress (RUN or DONE)
//   done         : one-cycle pulse, product valid
//   product      : last completed 2N-bit product
// Modports: master (requester side), slave (controller side).
interface shift_add_controller_if #(
  parameter int N = 8
);
  import shift_add_controller_pkg::*;

  logic                   start;
  logic [N-1:0]           multiplicand;
  logic [N-1:0]           multiplier;
  logic                   busy;
  logic                   done;
  logic [prod_w(N)-1:0]   product;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output busy,
    output done,
    output product
  );

endinterface

// File: rtl/shift_add_controller.sv
// Control and accumulator stage of a sequential N x N shift-add multiplier.
// The multiplier operand lives in an external shift register: it is loaded
// with B on an accepted start, then shifted right once per RUN cycle. Its
// LSB selects whether A is added into the accumulator, and the LSB of each
// partial sum is shifted back into the register's MSB, so after N shifts
// the register holds the low product half and the accumulator the high one.
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous, active-high reset (aborts a multiply in flight)
//   bus       : request/response bus (slave side)
//   lsb_in    : serial output Q[0] of the shift register
//   lo_in     : parallel output of the shift register (low product half)
//   sr_load   : shift-register parallel-load select
//   sr_enable : shift-register clock enable
//   sr_data   : shift-register parallel-load data (operand B)
//   sr_msb    : bit shifted into the shift register's MSB
module shift_add_controller
  import shift_add_controller_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_add_controller_if.slave bus,
  input  logic                  lsb_in,
  input  logic [N-1:0]          lo_in,
  output logic                  sr_load,
  output logic                  sr_enable,
  output logic [N-1:0]          sr_data,
  output logic                  sr_msb
);

  localparam int CNT_W = cnt_w(N);
  localparam int PW    = prod_w(N);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N - 1);

  state_t           state_reg;
  logic [N-1:0]     acc_reg;
  logic [N-1:0]     mcand_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PW-1:0]    product_reg;
  logic             done_reg;

  // One extra bit so the carry out of acc + A is kept; it becomes the
  // accumulator MSB after the right shift.
  logic [N:0]       sum_next;

  assign sum_next = {1'b0, acc_reg} + {1'b0, (lsb_in ? mcand_reg : {N{1'b0}})};

  // Shift-register control follows straight from state so the register
  // loads B on the very edge that accepts the start.
  always_comb begin
    sr_load   = 1'b0;
    sr_enable = 1'b0;
    sr_msb    = 1'b0;
    sr_data   = bus.multiplier;
    case (state_reg)
      IDLE: begin
        sr_load   = bus.start;
        sr_enable = bus.start;
      end
      RUN: begin
        sr_enable = 1'b1;
        sr_msb    = sum_next[0];
      end
      default: begin
        sr_enable = 1'b0;
      end
    endcase
  end

  assign bus.busy    = (state_reg != IDLE);
  assign bus.done    = done_reg;
  assign bus.product = product_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      count_reg   <= '0;
      product_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            mcand_reg <= bus.multiplicand;
            acc_reg   <= '0;
            count_reg <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg   <= sum_next[N:1];
          count_reg <= count_reg + CNT_W'(1);
          if (count_reg == LAST_COUNT) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          // Shift register is frozen here, so lo_in holds the low half.
          product_reg <= {acc_reg, lo_in};
          done_reg    <= 1'b1;
          state_reg   <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_controller.sv
// Self-checking bench for shift_add_controller, paired with a behavioural
// N-bit serial shift register. Expected products are queued when a start is
// accepted and popped when done pulses.
module tb_shift_add_controller;

  localparam int N  = 8;
  localparam int PW = 2 * N;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  shift_add_controller_if #(.N(N)) bus ();

  logic          lsb_in;
  logic [N-1:0]  lo_in;
  logic          sr_load;
  logic          sr_enable;
  logic [N-1:0]  sr_data;
  logic          sr_msb;

  shift_add_controller #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .lsb_in    (lsb_in),
    .lo_in     (lo_in),
    .sr_load   (sr_load),
    .sr_enable (sr_enable),
    .sr_data   (sr_data),
    .sr_msb    (sr_msb)
  );

  // Behavioural serial_register: parallel load or right shift with msb in.
  logic [N-1:0] sr_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else if (sr_enable) begin
      sr_q <= sr_load ? sr_data : {sr_msb, sr_q[N-1:1]};
    end
  end
  assign lsb_in = sr_q[0];
  assign lo_in  = sr_q;

  int vectors     = 0;
  int miscompares = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued product.
  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_val = exp_q.pop_front();
        $display("txn: product=%04h expected=%04h", bus.product, exp_val);
        check("product", 32'(bus.product), 32'(exp_val));
      end
    end
  end

  // Waits up to 20 cycles for done; returns its negedge index after the
  // accepting edge and the number of busy cycles before it.
  task automatic wait_done(input int drop_start_at, output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == drop_start_at) bus.start = 1'b0;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic apply(input logic [N-1:0] a, input logic [N-1:0] b, input logic [PW-1:0] e);
    int lat;
    int bc;
    @(negedge clk);
    check("idle_before_start", 32'(bus.busy), 32'd0);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    #1;
    check("sr_load_on_start", 32'(sr_load), 32'd1);
    check("sr_data_on_start", 32'(sr_data), 32'(b));
    @(posedge clk);
    exp_q.push_back(e);
    #1 bus.start = 1'b0;
    wait_done(0, lat, bc);
    check("done_latency", lat, 32'd10);
    check("busy_cycles", bc, 32'd9);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_product", 32'(bus.product), 32'd0);
    check("rst_sr_enable", 32'(sr_enable), 32'd0);
    check("rst_sr_load", 32'(sr_load), 32'd0);
    check("rst_sr_msb", 32'(sr_msb), 32'd0);
  endtask

  typedef struct {
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [PW-1:0] e;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int lat;
    int bc;
    int done_seen;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    tbl[0] = '{8'd13,  8'd11,  16'h008F};
    tbl[1] = '{8'd255, 8'd255, 16'hFE01};
    tbl[2] = '{8'd0,   8'd200, 16'h0000};
    tbl[3] = '{8'd200, 8'd0,   16'h0000};
    tbl[4] = '{8'd1,   8'd1,   16'h0001};
    tbl[5] = '{8'd128, 8'd2,   16'h0100};
    tbl[6] = '{8'd170, 8'd85,  16'h3872};
    ra = 8'($urandom_range(0, 255));
    rb = 8'($urandom_range(0, 255));
    tbl[7] = '{ra, rb, 16'(ra) * 16'(rb)};
    ra = 8'($urandom_range(0, 255));
    rb = 8'($urandom_range(0, 255));
    tbl[8] = '{ra, rb, 16'(ra) * 16'(rb)};

    do_reset();

    foreach (tbl[i]) apply(tbl[i].a, tbl[i].b, tbl[i].e);

    // Start and operand changes during RUN must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 8'd7; bus.multiplier = 8'd9;
    @(posedge clk);
    exp_q.push_back(16'h003F);
    #1 bus.multiplicand = 8'd3; bus.multiplier = 8'd3;
    @(negedge clk);
    check("run_sr_enable", 32'(sr_enable), 32'd1);
    check("run_sr_load", 32'(sr_load), 32'd0);
    check("product_held_in_run", 32'(bus.product), 32'(tbl[8].e));
    wait_done(4, lat, bc);
    check("ignored_start_latency", lat, 32'd9);
    repeat (12) @(negedge clk);
    check("ignored_start_idle", 32'(bus.busy), 32'd0);

    // Back-to-back: start held through the done cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 8'd12; bus.multiplier = 8'd12;
    @(posedge clk);
    exp_q.push_back(16'h0090);
    #1 bus.multiplicand = 8'd5; bus.multiplier = 8'd6;
    wait_done(0, lat, bc);
    check("b2b_first_latency", lat, 32'd10);
    #1;
    check("b2b_sr_load", 32'(sr_load), 32'd1);
    check("b2b_sr_data", 32'(sr_data), 32'd6);
    @(posedge clk);
    exp_q.push_back(16'h001E);
    #1 bus.start = 1'b0;
    check("b2b_product_held", 32'(bus.product), 32'h0090);
    wait_done(0, lat, bc);
    check("b2b_second_latency", lat, 32'd10);

    // Reset mid-RUN aborts without a done pulse.
    do_reset();
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 8'd100; bus.multiplier = 8'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_product", 32'(bus.product), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    check("abort_no_done", done_seen, 32'd0);
    apply(8'd100, 8'd3, 16'h012C);

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
